hlsm_cmpsel_w: RTL and testbench

//  Parametrised successor of the HLS-generated compare/select datapath FSM.
//  - On Start, latches a, b, c and computes:
//      d=a+b, e=a+c, f=a-b,
//      g = (d<e) ? d : e,
//      h = (d==e) ? g : f,
//      x = g << (d<e),
//      z = h >> (d==e).
//  - Adds width/signedness parameters, input latching, Busy, back-to-back starts and optional overflow flag.
//  - Sits under the HLS top as a reusable scheduled-datapath leaf.

---
 rtl/hlsm_pkg.sv | 21 ++
 rtl/hlsm_cmpsel_w_if.sv | 44 ++++
 rtl/hlsm_cmp_unit.sv | 28 ++
 rtl/hlsm_cmpsel_w.sv | 168 ++++++++++++++++
 tb/tb_hlsm_cmpsel_w.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/hlsm_pkg.sv
// ----------------------------------------------------------------------------
// hlsm_pkg
// Shared definitions for the hlsm_cmpsel_w compare/select datapath leaf:
// state register width and the 3-bit state encoding (Wait=0 .. Final=6).
// No ports.
// ----------------------------------------------------------------------------
package hlsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT  = 3'd0,
        S_1     = 3'd1,
        S_2     = 3'd2,
        S_3     = 3'd3,
        S_4     = 3'd4,
        S_5     = 3'd5,
        S_FINAL = 3'd6
    } state_t;

endpackage

// File: rtl/hlsm_cmpsel_w_if.sv
// ----------------------------------------------------------------------------
// hlsm_cmpsel_w_if
// Run/operand/result bundle for hlsm_cmpsel_w.
//   Start      run request (master -> slave)
//   a, b, c    operands    (master -> slave)
//   Busy       state != Wait
//   Done       state == Final
//   x, z       registered results
//   Ovf        overflow flag, only when HLSM_OVF_FLAG_EN is defined
// Parameter DATAWIDTH must match the attached hlsm_cmpsel_w instance.
// ----------------------------------------------------------------------------
interface hlsm_cmpsel_w_if #(
    parameter int DATAWIDTH = 32
) ();

    logic                 Start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 Busy;
    logic                 Done;
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] z;
`ifdef HLSM_OVF_FLAG_EN
    logic                 Ovf;
`endif

    modport slave (
        input  Start, a, b, c,
`ifdef HLSM_OVF_FLAG_EN
        output Ovf,
`endif
        output Busy, Done, x, z
    );

    modport master (
        output Start, a, b, c,
`ifdef HLSM_OVF_FLAG_EN
        input  Ovf,
`endif
        input  Busy, Done, x, z
    );

endinterface

// File: rtl/hlsm_cmp_unit.sv
// ----------------------------------------------------------------------------
// hlsm_cmp_unit
// Combinational comparator for the d/e intermediates.
//   d, e   in   DATAWIDTH  values to compare
//   eq     out  1          d == e
//   lt     out  1          d <  e (two's complement when SIGNED=1)
// ----------------------------------------------------------------------------
module hlsm_cmp_unit #(
    parameter int DATAWIDTH = 32,
    parameter bit SIGNED    = 1'b0
) (
    input  logic [DATAWIDTH-1:0] d_i,
    input  logic [DATAWIDTH-1:0] e_i,
    output logic                 eq_o,
    output logic                 lt_o
);

    assign eq_o = (d_i == e_i);

    generate
        if (SIGNED) begin : g_signed
            assign lt_o = ($signed(d_i) < $signed(e_i));
        end else begin : g_unsigned
            assign lt_o = (d_i < e_i);
        end
    endgenerate

endmodule

// File: rtl/hlsm_cmpsel_w.sv
// ----------------------------------------------------------------------------
// hlsm_cmpsel_w
// Scheduled compare/select datapath leaf. On Start the operands are latched
// and over five datapath states it computes
//   d=a+b, e=a+c, f=a-b, g=(d<e)?d:e, h=(d==e)?g:f, x=g<<(d<e), z=h>>(d==e)
// presenting x/z in Final. Start in Final chains directly into a new run.
// Ports:
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset
//   bus    hlsm_cmpsel_w_if.slave (Start, a, b, c, Busy, Done, x, z[, Ovf])
// Optional feature macro: HLSM_OVF_FLAG_EN (adds Ovf = overflow on d, e, f).
//
// state  | meaning
// S_WAIT | idle, waiting for Start
// S_1    | compute d, e
// S_2    | compute f, d==e, d<e
// S_3    | compute g
// S_4    | compute h, x_int
// S_5    | compute z_int, load outputs
// S_FINAL| Done; Start chains a new run
// ----------------------------------------------------------------------------
module hlsm_cmpsel_w
    import hlsm_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter bit SIGNED    = 1'b0
) (
    input  logic          Clk,
    input  logic          Rst_n,
    hlsm_cmpsel_w_if.slave bus
);

    state_t state_q, state_d;

    logic [DATAWIDTH-1:0] a_q, b_q, c_q;
    logic [DATAWIDTH-1:0] d_q, e_q, f_q, g_q, h_q;
    logic [DATAWIDTH-1:0] x_int_q, z_int_q;
    logic [DATAWIDTH-1:0] x_q, z_q;
    logic                 eq_q, lt_q;

    logic                 eq_w, lt_w;
    logic                 run_start;
    logic [DATAWIDTH-1:0] h_shr;
    logic [DATAWIDTH-1:0] z_next;

    hlsm_cmp_unit #(
        .DATAWIDTH (DATAWIDTH),
        .SIGNED    (SIGNED)
    ) u_cmp (
        .d_i  (d_q),
        .e_i  (e_q),
        .eq_o (eq_w),
        .lt_o (lt_w)
    );

    assign run_start = ((state_q == S_WAIT) || (state_q == S_FINAL)) && bus.Start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  state_d = bus.Start ? S_1 : S_WAIT;
            S_1:     state_d = S_2;
            S_2:     state_d = S_3;
            S_3:     state_d = S_4;
            S_4:     state_d = S_5;
            S_5:     state_d = S_FINAL;
            S_FINAL: state_d = bus.Start ? S_1 : S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= S_WAIT;
        else        state_q <= state_d;
    end

    // Shift by the 1-bit eq flag: either h unchanged or h shifted right once.
    assign h_shr  = SIGNED ? {h_q[DATAWIDTH-1], h_q[DATAWIDTH-1:1]}
                           : {1'b0, h_q[DATAWIDTH-1:1]};
    assign z_next = eq_q ? h_shr : h_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            x_int_q <= '0;
            z_int_q <= '0;
            x_q     <= '0;
            z_q     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            if (run_start) begin
                a_q <= bus.a;
                b_q <= bus.b;
                c_q <= bus.c;
            end
            case (state_q)
                S_1: begin
                    d_q <= a_q + b_q;
                    e_q <= a_q + c_q;
                end
                S_2: begin
                    f_q  <= a_q - b_q;
                    eq_q <= eq_w;
                    lt_q <= lt_w;
                end
                S_3: g_q <= lt_q ? d_q : e_q;
                S_4: begin
                    h_q     <= eq_q ? g_q : f_q;
                    x_int_q <= g_q << lt_q;
                end
                S_5: begin
                    // z_int is produced on this same edge, so the output takes
                    // the value being written rather than the stale register.
                    z_int_q <= z_next;
                    z_q     <= z_next;
                    x_q     <= x_int_q;
                end
                default: ;
            endcase
        end
    end

`ifdef HLSM_OVF_FLAG_EN
    logic [DATAWIDTH:0] add_ab_w, add_ac_w, sub_ab_w;
    logic               ovf_d_w, ovf_e_w, ovf_f_w;
    logic               ovf_q;
    localparam int      MSB = DATAWIDTH - 1;

    assign add_ab_w = {1'b0, a_q} + {1'b0, b_q};
    assign add_ac_w = {1'b0, a_q} + {1'b0, c_q};
    assign sub_ab_w = {1'b0, a_q} - {1'b0, b_q};

    generate
        if (SIGNED) begin : g_ovf_s
            assign ovf_d_w = (a_q[MSB] == b_q[MSB]) && (add_ab_w[MSB] != a_q[MSB]);
            assign ovf_e_w = (a_q[MSB] == c_q[MSB]) && (add_ac_w[MSB] != a_q[MSB]);
            assign ovf_f_w = (a_q[MSB] != b_q[MSB]) && (sub_ab_w[MSB] != a_q[MSB]);
        end else begin : g_ovf_u
            assign ovf_d_w = add_ab_w[DATAWIDTH];
            assign ovf_e_w = add_ac_w[DATAWIDTH];
            assign ovf_f_w = sub_ab_w[DATAWIDTH];
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                ovf_q <= 1'b0;
        else if (run_start)        ovf_q <= 1'b0;
        else if (state_q == S_1)   ovf_q <= ovf_d_w | ovf_e_w;
        else if (state_q == S_2)   ovf_q <= ovf_q | ovf_f_w;
    end

    assign bus.Ovf = ovf_q;
`endif

    assign bus.Busy = (state_q != S_WAIT);
    assign bus.Done = (state_q == S_FINAL);
    assign bus.x    = x_q;
    assign bus.z    = z_q;

endmodule

// File: tb/tb_hlsm_cmpsel_w.sv
// ----------------------------------------------------------------------------
// tb_hlsm_cmpsel_w
// Drives an unsigned and a signed hlsm_cmpsel_w (DATAWIDTH=32) with identical
// directed stimulus, checks both against an arithmetic model every cycle and
// against hand-computed literals at selected points.
// ----------------------------------------------------------------------------
module tb_hlsm_cmpsel_w;

    localparam int DW = 32;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    hlsm_cmpsel_w_if #(.DATAWIDTH(DW)) bu ();
    hlsm_cmpsel_w_if #(.DATAWIDTH(DW)) bs ();

    hlsm_cmpsel_w #(.DATAWIDTH(DW), .SIGNED(1'b0)) dut_u (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bu.slave)
    );

    hlsm_cmpsel_w #(.DATAWIDTH(DW), .SIGNED(1'b1)) dut_s (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bs.slave)
    );

    int nvec  = 0;
    int nfail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic st, input logic [31:0] a, b, c);
        bu.Start = st; bu.a = a; bu.b = b; bu.c = c;
        bs.Start = st; bs.a = a; bs.b = b; bs.c = c;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;
    localparam longint MAXU = 64'sd4294967295;

    function automatic void model(input logic [31:0] a, b, c, input bit sg,
                                  output logic [31:0] xo, zo, output logic ov);
        logic [31:0] d, e, f, g, h;
        logic        lt, eq;
        longint      sd, se, sf;
        d = a + b;
        e = a + c;
        f = a - b;
        if (sg) begin
            sd = longint'(int'(a)) + longint'(int'(b));
            se = longint'(int'(a)) + longint'(int'(c));
            sf = longint'(int'(a)) - longint'(int'(b));
            ov = (sd > MAXS) || (sd < MINS) || (se > MAXS) || (se < MINS) ||
                 (sf > MAXS) || (sf < MINS);
            lt = ($signed(d) < $signed(e));
        end else begin
            sd = longint'({32'b0, a}) + longint'({32'b0, b});
            se = longint'({32'b0, a}) + longint'({32'b0, c});
            sf = longint'({32'b0, a}) - longint'({32'b0, b});
            ov = (sd > MAXU) || (se > MAXU) || (sf < 0);
            lt = (d < e);
        end
        eq = (d == e);
        g  = lt ? d : e;
        h  = eq ? g : f;
        xo = lt ? g * 2 : g;
        if (!eq)     zo = h;
        else if (sg) zo = $signed(h) >>> 1;
        else         zo = h >> 1;
    endfunction

    // ph: 0 idle, 1..5 computing, 6 results presented
    int          ph = 0;
    logic [31:0] la, lb, lc;
    logic [31:0] exp_x [2];
    logic [31:0] exp_z [2];
    logic        exp_o [2];

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ph = 0;
            for (int i = 0; i < 2; i++) begin
                exp_x[i] = '0; exp_z[i] = '0; exp_o[i] = 1'b0;
            end
        end else if (ph == 0 || ph == 6) begin
            if (bu.Start) begin
                ph = 1; la = bu.a; lb = bu.b; lc = bu.c;
            end else begin
                ph = 0;
            end
        end else begin
            ph++;
            if (ph == 6) begin
                model(la, lb, lc, 1'b0, exp_x[0], exp_z[0], exp_o[0]);
                model(la, lb, lc, 1'b1, exp_x[1], exp_z[1], exp_o[1]);
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("busy_u", {31'b0, bu.Busy}, {31'b0, ph != 0});
            chk("done_u", {31'b0, bu.Done}, {31'b0, ph == 6});
            chk("x_u",    bu.x, exp_x[0]);
            chk("z_u",    bu.z, exp_z[0]);
            chk("busy_s", {31'b0, bs.Busy}, {31'b0, ph != 0});
            chk("done_s", {31'b0, bs.Done}, {31'b0, ph == 6});
            chk("x_s",    bs.x, exp_x[1]);
            chk("z_s",    bs.z, exp_z[1]);
`ifdef HLSM_OVF_FLAG_EN
            if (ph == 0 || ph == 6) begin
                chk("ovf_u", {31'b0, bu.Ovf}, {31'b0, exp_o[0]});
                chk("ovf_s", {31'b0, bs.Ovf}, {31'b0, exp_o[1]});
            end
`endif
        end
    end

    // One pulsed run; operands are scrambled after the latch edge. Literal
    // expectations are checked when Done appears.
    task automatic run(input string nm, input logic [31:0] a, b, c,
                       input logic [31:0] xu, zu, xs, zs);
        int n;
        set_in(1'b1, a, b, c);
        tick();
        set_in(1'b0, ~a, ~b, ~c);
        n = 0;
        while (!bu.Done && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, n, 5);
        chk({nm, "_xu"}, bu.x, xu);
        chk({nm, "_zu"}, bu.z, zu);
        chk({nm, "_xs"}, bs.x, xs);
        chk({nm, "_zs"}, bs.z, zs);
        tick();
    endtask

    logic [31:0] va [4] = '{32'd10, 32'd4, 32'd0,          32'd1};
    logic [31:0] vb [4] = '{32'd3,  32'd2, 32'hFFFFFFFF,   32'd1};
    logic [31:0] vc [4] = '{32'd5,  32'd2, 32'd1,          32'd1};

    initial begin
        set_in(1'b0, '0, '0, '0);
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", {31'b0, bu.Busy}, 32'd0);
        chk("rst_done", {31'b0, bs.Done}, 32'd0);
        chk("rst_x",    bu.x, 32'd0);
        chk("rst_z",    bs.z, 32'd0);
        Rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        run("t1", 32'd10, 32'd3, 32'd5, 32'd26, 32'd7, 32'd26, 32'd7);
        run("t2", 32'd4, 32'd2, 32'd2, 32'd6, 32'd3, 32'd6, 32'd3);
        run("t3", 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFE, 32'd1);
        run("neg", 32'hFFFFFFFC, 32'hFFFFFFFE, 32'hFFFFFFFE,
            32'hFFFFFFFA, 32'h7FFFFFFD, 32'hFFFFFFFA, 32'hFFFFFFFD);
        run("t6a", 32'h7FFFFFFF, 32'd1, 32'd0,
            32'h7FFFFFFF, 32'h7FFFFFFE, 32'h00000000, 32'h7FFFFFFE);
`ifdef HLSM_OVF_FLAG_EN
        chk("t6a_ovf_s", {31'b0, bs.Ovf}, 32'd1);
        chk("t6a_ovf_u", {31'b0, bu.Ovf}, 32'd0);
`endif
        run("t6b", 32'd1, 32'd1, 32'd1, 32'd2, 32'd1, 32'd2, 32'd1);
`ifdef HLSM_OVF_FLAG_EN
        chk("t6b_ovf_s", {31'b0, bs.Ovf}, 32'd0);
`endif

        // back-to-back runs with Start held high
        set_in(1'b1, va[0], vb[0], vc[0]);
        tick();
        for (int k = 1; k < 4; k++) begin
            set_in(1'b1, va[k], vb[k], vc[k]);
            repeat (6) tick();
            chk("b2b_busy", {31'b0, bu.Busy}, 32'd1);
        end
        set_in(1'b0, 32'hDEAD0000, 32'h1234, 32'h5678);
        repeat (5) tick();
        chk("b2b_done", {31'b0, bu.Done}, 32'd1);
        chk("b2b_x", bu.x, 32'd2);
        chk("b2b_z", bu.z, 32'd1);
        tick();

        // reset asserted in S3
        set_in(1'b1, 32'd10, 32'd3, 32'd5);
        tick();
        set_in(1'b0, 32'd10, 32'd3, 32'd5);
        tick();
        tick();
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, bu.Busy}, 32'd0);
        chk("mid_rst_done", {31'b0, bs.Done}, 32'd0);
        chk("mid_rst_x",    bu.x, 32'd0);
        chk("mid_rst_z",    bs.z, 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();
        run("post_rst", 32'd10, 32'd3, 32'd5, 32'd26, 32'd7, 32'd26, 32'd7);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
